// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared save-SRAM layout constants and save-reader FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package md_pkg;

    // Save SRAM location inside SDRAM; shared with the SDRAM layout map.
    localparam logic [23:0] SRAM_BASE      = 24'h820000;
    localparam int          SRAM_MAX_BYTES = 131072;

    // Save-reader sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HI    = 3'd3,
        ST_LO    = 3'd4,
        ST_DRAIN = 3'd5
    } save_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/md_save_reader.sv
`default_nettype none
// ============================================================================
//  Module      : md_save_reader
//  Description : Streams a region of save SRAM out of SDRAM (16-bit
//                big-endian words, toggle req/ack) as a valid/ready byte
//                stream for backup by iosys.
//  Revision    : 1.0  initial release
// ============================================================================
module md_save_reader
    import md_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = SRAM_BASE,
    parameter int          MAX_LEN   = SRAM_MAX_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] len_bytes,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [24:1] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [1:0]  mem_be,
    output logic        mem_we,
    input  logic [15:0] mem_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [17:0] C_MAX_LEN   = 18'(MAX_LEN);
    localparam logic [23:0] C_BASE_WORD = {1'b0, BASE_ADDR[23:1]};

    save_rd_state_t r_state, w_state_nxt;
    logic [17:0]    r_remaining, w_remaining_nxt;
    logic [23:0]    r_addr, w_addr_nxt;
    logic           r_req, w_req_nxt;
    logic [15:0]    r_word, w_word_nxt;
    logic           r_done, w_done_nxt;
    logic           r_aborted, w_aborted_nxt;
    logic           r_in_reset;

    logic [17:0]    w_len_clamped;
    logic [17:0]    w_rem_dec;
    logic           w_ack_match;
    logic           w_hs;

    assign w_len_clamped = (len_bytes > C_MAX_LEN) ? C_MAX_LEN : len_bytes;
    assign w_rem_dec     = r_remaining - 18'd1;
    assign w_ack_match   = (r_req == mem_ack);
    assign w_hs          = out_valid && out_ready;

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign mem_addr  = r_addr;
    assign mem_req   = r_req;
    assign mem_be    = 2'b11;
    assign mem_we    = 1'b0;
    assign out_valid = (r_state == ST_HI) || (r_state == ST_LO);
    assign out_data  = (r_state == ST_HI) ? r_word[15:8] :
                       (r_state == ST_LO) ? r_word[7:0]  : 8'h00;

    // State and datapath registers; r_in_reset marks the first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_addr      <= '0;
            r_req       <= 1'b0;
            r_word      <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_in_reset  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_addr      <= w_addr_nxt;
            r_req       <= w_req_nxt;
            r_word      <= w_word_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_in_reset  <= 1'b0;
        end
    end

    // Next-state logic: request a word, emit high then low byte, repeat.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_addr_nxt      = r_addr;
        w_req_nxt       = r_req;
        w_word_nxt      = r_word;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;

        // Adopt the controller's ack level so no request looks outstanding.
        if (r_in_reset) begin
            w_req_nxt = mem_ack;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_len_clamped == 18'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_remaining_nxt = w_len_clamped;
                        w_addr_nxt      = C_BASE_WORD;
                        w_state_nxt     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (abort) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_ack_match) begin
                    // Only issue when nothing (e.g. a stale read) is in flight.
                    w_req_nxt   = ~r_req;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_ack_match) begin
                    w_word_nxt  = mem_data;
                    w_state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (w_hs) begin
                    w_remaining_nxt = w_rem_dec;
                    // The final byte completes normally even with abort raised.
                    if (w_rem_dec == 18'd0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (abort) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_LO;
                    end
                end else if (abort) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_LO: begin
                if (w_hs) begin
                    w_remaining_nxt = w_rem_dec;
                    w_addr_nxt      = r_addr + 24'd1;
                    if (w_rem_dec == 18'd0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if (abort) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else if (abort) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Let any in-flight read land before reporting the abort.
                if (w_ack_match) begin
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
